// File: rtl/uart_rx_subsystem.sv
// ============================================================================
// Module   : uart_rx_subsystem
// Brief    : Baud-tick generator, 16x-oversampling UART receiver and an
//            inferred FWFT receive FIFO with sticky error flags.
//            Optional parity check enabled by defining UART_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_subsystem #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int ADDR_W  = 4,
  parameter int TV_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [TV_W-1:0]   TIMER_FINAL_VALUE,
  input  logic              parity_odd,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  input  logic              clr_err
);

  localparam int              c_DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(c_DEPTH);
  localparam logic [5:0]      c_S_STOP    = 6'(SB_TICK-1);
  localparam logic [3:0]      c_N_LAST    = 4'(DBIT-1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // ---------------- baud tick generator ----------------
  logic [TV_W-1:0] r_baud_cnt;
  logic            w_tick;

  // Equality compare: a counter already past a new, smaller final value
  // free-runs to its maximum and wraps naturally.
  assign w_tick = (r_baud_cnt == TIMER_FINAL_VALUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + TV_W'(1);
  end

  // ---------------- rx synchroniser ----------------
  logic r_rx_meta, r_rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // ---------------- receiver FSM ----------------
  state_t          r_state;
  logic [5:0]      r_s;
  logic [3:0]      r_n;
  logic [DBIT-1:0] r_shift;
  logic            r_armed;
  logic            r_push;
  logic            r_frame_err;
  logic            r_parity_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_shift      <= '0;
      r_armed      <= 1'b0;
      r_push       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (clr_err) begin
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_rx_sync) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= ST_START;
            r_s     <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_s == 6'd7) begin
              if (!r_rx_sync) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 6'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_s == 6'd15) begin
              r_s     <= '0;
              r_shift <= {r_rx_sync, r_shift[DBIT-1:1]};
              if (r_n == c_N_LAST) begin
`ifdef UART_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_n <= r_n + 4'd1;
              end
            end else begin
              r_s <= r_s + 6'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            if (r_s == 6'd15) begin
              if (r_rx_sync != ((^r_shift) ^ parity_odd))
                r_parity_err <= 1'b1;
              r_state <= ST_STOP;
              r_s     <= '0;
            end else begin
              r_s <= r_s + 6'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_s == c_S_STOP) begin
              if (!r_rx_sync) r_frame_err <= 1'b1;
              r_push  <= 1'b1;
              r_armed <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_s <= r_s + 6'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  assign parity_err = r_parity_err;
`else
  logic w_unused_parity;
  assign w_unused_parity = parity_odd ^ r_parity_err;
  assign parity_err      = 1'b0;
`endif
  assign frame_err = r_frame_err;

  // ---------------- receive FIFO ----------------
  logic [DBIT-1:0]   r_mem [c_DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;
  logic              w_full, w_empty, w_pop, w_wr;

  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = rd_uart & ~w_empty;
  assign w_wr    = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop) r_rptr <= r_rptr + ADDR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (clr_err) r_overrun <= 1'b0;
      if (r_push && w_full && !rd_uart) r_overrun <= 1'b1;
    end
  end

  assign r_data     = w_empty ? '0 : r_mem[r_rptr];
  assign rx_empty   = w_empty;
  assign rx_full    = w_full;
  assign fifo_count = r_count;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_subsystem.sv
// ============================================================================
// Module   : tb_uart_rx_subsystem
// Brief    : Scoreboard bench for uart_rx_subsystem (DBIT=8, ADDR_W=2, 64 clk/bit).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_subsystem;

  localparam int DBIT     = 8;
  localparam int ADDR_W   = 2;
  localparam int TV_W     = 11;
  localparam int BIT_CLKS = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic [TV_W-1:0] tfv;
  logic            parity_odd;
  logic            rd_uart;
  logic            clr_err;
  logic [DBIT-1:0] r_data;
  logic            rx_empty, rx_full;
  logic [ADDR_W:0] fifo_count;
  logic            frame_err, parity_err, overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
`ifdef UART_PARITY_EN
  logic       par_flip;
`endif

  uart_rx_subsystem #(.DBIT(DBIT), .SB_TICK(16), .ADDR_W(ADDR_W), .TV_W(TV_W)) dut (
    .clk(clk), .rst(rst), .rx(rx), .TIMER_FINAL_VALUE(tfv), .parity_odd(parity_odd),
    .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .fifo_count(fifo_count), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cyc(BIT_CLKS);
  endtask

  // Frame with chosen stop level; optionally keep the line low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int extra_low_bits);
    send_bit(1'b0);
    for (int i = 0; i < DBIT; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ parity_odd ^ par_flip);
`endif
    send_bit(stop_b);
    if (extra_low_bits > 0) cyc(extra_low_bits * BIT_CLKS);
    rx = 1'b1;
    cyc(BIT_CLKS / 2);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(1);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      int t = 0;
      while (rx_empty && t < 1000) begin
        cyc(1);
        t++;
      end
      if (rx_empty) begin
        check("drain_timeout", {31'd0, rx_empty}, 32'd0);
        exp_q.delete();
      end else begin
        check("r_data", {24'd0, r_data}, {24'd0, exp_q.pop_front()});
        rd_uart = 1'b1;
        cyc(1);
        rd_uart = 1'b0;
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; tfv = TV_W'(3); parity_odd = 1'b0;
    rd_uart = 1'b0; clr_err = 1'b0;
`ifdef UART_PARITY_EN
    par_flip = 1'b0;
`endif
    cyc(5);
    rst = 1'b0;
    cyc(3);
    check("rst_empty", rx_empty, 1);
    check("rst_full", rx_full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_rdata", r_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);

    // Single byte round trip
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0);
    check("a5_count", fifo_count, 1);
    check("a5_empty", rx_empty, 0);
    drain();
    check("a5_empty_after", rx_empty, 1);
    check("a5_count_after", fifo_count, 0);

    // Fill past capacity
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
      if (i == 4) begin
        check("fill_full", rx_full, 1);
        check("fill_count", fifo_count, 4);
        check("fill_no_ovr", overrun, 0);
      end
    end
    check("ovr_set", overrun, 1);
    check("ovr_count", fifo_count, 4);
    drain();
    check("ovr_drained", rx_empty, 1);
    check("ovr_sticky", overrun, 1);
    pulse_clr();
    check("ovr_clr", overrun, 0);

    // Short start glitch is rejected
    rx = 1'b0;
    cyc(16);
    rx = 1'b1;
    cyc(200);
    check("glitch_empty", rx_empty, 1);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", frame_err, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0);
    drain();

    // Framing error with line stuck low afterwards
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 3);
    check("ferr_set", frame_err, 1);
    check("ferr_one_push", fifo_count, 1);
    cyc(200);
    check("ferr_still_one", fifo_count, 1);
    drain();
    pulse_clr();
    check("ferr_clr", frame_err, 0);

`ifdef UART_PARITY_EN
    parity_odd = 1'b0;
    par_flip   = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 0);
    check("par_err_set", parity_err, 1);
    drain();
    pulse_clr();
    check("par_err_clr", parity_err, 0);
    par_flip = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 0);
    check("par_ok", parity_err, 0);
    drain();
`else
    check("par_tied", parity_err, 0);
`endif

    // Reset in the middle of a frame with data buffered
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0);
    check("mid_pre_count", fifo_count, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    cyc(10);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", rx_empty, 1);
    rx = 1'b1;
    cyc(3);
    rst = 1'b0;
    exp_q.delete();
    cyc(2);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0);
    check("post_rst_count", fifo_count, 1);
    drain();
    check("post_rst_empty", rx_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
